// File: rtl/count_enable_gen.sv
// count_enable_gen: programmable-rate / single-step enable pulse source for the up counter (optional STEP_SYNC_EN input synchronizers)
module count_enable_gen #(
   parameter int DIV_WIDTH = 8
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 Run,
   input  logic                 Step,
   input  logic [DIV_WIDTH-1:0] Div,
   output logic                 En,
   output logic [1:0]           State,
   output logic [DIV_WIDTH-1:0] Phase
);
   typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, STEP = 2'b10} state_t;
   state_t state;
   logic run_s, step_s, step_q, step_rise;
`ifdef STEP_SYNC_EN
   logic [1:0] run_sync, step_sync;
   // two-flop synchronizers; Step resets high so a held button gives no pulse
   always_ff @(posedge Clk)
      if (!Rst_n) begin
         run_sync  <= 2'b00;
         step_sync <= 2'b11;
      end else begin
         run_sync  <= {run_sync[0], Run};
         step_sync <= {step_sync[0], Step};
      end
   assign run_s  = run_sync[1];
   assign step_s = step_sync[1];
`else
   assign run_s  = Run;
   assign step_s = Step;
`endif
   assign step_rise = step_s & ~step_q;
   assign State     = state;
   // mode FSM with prescaler and registered enable pulse
   always_ff @(posedge Clk)
      if (!Rst_n) begin
         state  <= IDLE;
         Phase  <= '0;
         En     <= 1'b0;
         step_q <= 1'b1;
      end else begin
         step_q <= step_s;
         case (state)
            IDLE:
               if (run_s) begin
                  state <= RUN;
                  Phase <= '0;
                  En    <= 1'b0;
               end else if (step_rise) begin
                  state <= STEP;
                  En    <= 1'b1;
               end else
                  En <= 1'b0;
            RUN:
               if (!run_s) begin
                  state <= IDLE;
                  Phase <= '0;
                  En    <= 1'b0;
               end else if (Phase >= Div) begin
                  Phase <= '0;
                  En    <= 1'b1;
               end else begin
                  Phase <= Phase + 1'b1;
                  En    <= 1'b0;
               end
            default: begin
               state <= IDLE;
               En    <= 1'b0;
            end
         endcase
      end
endmodule

// File: tb/tb_count_enable_gen.sv
// tb_count_enable_gen: directed self-checking bench for count_enable_gen (default build)
module tb_count_enable_gen;
   logic       Clk = 1'b0;
   logic       Rst_n, Run, Step;
   logic [7:0] Div;
   logic       En;
   logic [1:0] State;
   logic [7:0] Phase;
   int         n_checks = 0;
   int         n_fail = 0;

   count_enable_gen #(.DIV_WIDTH(8)) dut (
      .Clk(Clk), .Rst_n(Rst_n), .Run(Run), .Step(Step), .Div(Div),
      .En(En), .State(State), .Phase(Phase)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) @(posedge Clk);
      #1;
   endtask

   task automatic expect_out(input string tag, input logic en, input logic [1:0] st, input logic [7:0] ph);
      check({tag, ".en"}, En, en);
      check({tag, ".state"}, State, st);
      check({tag, ".phase"}, Phase, ph);
   endtask

   initial begin
      Rst_n = 1'b0; Run = 1'b1; Step = 1'b1; Div = 8'd3;
      tick(3);
      expect_out("reset", 1'b0, 2'b00, 8'd0);
      Rst_n = 1'b1; Run = 1'b0;
      tick();
      expect_out("rel1", 1'b0, 2'b00, 8'd0);
      tick();
      expect_out("rel2", 1'b0, 2'b00, 8'd0);
      Step = 1'b0;
      tick();
      // free run with Div=3: period 4
      Run = 1'b1;
      tick();
      expect_out("run_entry", 1'b0, 2'b01, 8'd0);
      for (int k = 1; k <= 12; k++) begin
         tick();
         expect_out($sformatf("run_k%0d", k), (k % 4) == 0, 2'b01, 8'(k % 4));
      end
      Run = 1'b0;
      tick();
      expect_out("run_exit", 1'b0, 2'b00, 8'd0);
      // single step held high
      Step = 1'b1;
      tick();
      expect_out("step_pulse", 1'b1, 2'b10, 8'd0);
      for (int k = 0; k < 9; k++) begin
         tick();
         expect_out($sformatf("step_hold%0d", k), 1'b0, 2'b00, 8'd0);
      end
      Step = 1'b0;
      tick();
      // Run and step rise together: Run wins
      Run = 1'b1; Step = 1'b1;
      tick();
      expect_out("prio", 1'b0, 2'b01, 8'd0);
      Step = 1'b0;
      tick();
      expect_out("prio_p1", 1'b0, 2'b01, 8'd1);
      Step = 1'b1;
      tick();
      expect_out("step_in_run", 1'b0, 2'b01, 8'd2);
      tick();
      expect_out("step_in_run2", 1'b0, 2'b01, 8'd3);
      tick();
      expect_out("step_in_run_wrap", 1'b1, 2'b01, 8'd0);
      Run = 1'b0;
      tick();
      expect_out("prio_exit", 1'b0, 2'b00, 8'd0);
      Step = 1'b0;
      tick();
      // lowering Div below Phase
      Div = 8'd10; Run = 1'b1;
      tick();
      tick(7);
      expect_out("div10_p7", 1'b0, 2'b01, 8'd7);
      Div = 8'd2;
      tick();
      expect_out("div_low_wrap", 1'b1, 2'b01, 8'd0);
      tick();
      expect_out("div2_p1", 1'b0, 2'b01, 8'd1);
      tick();
      expect_out("div2_p2", 1'b0, 2'b01, 8'd2);
      tick();
      expect_out("div2_wrap", 1'b1, 2'b01, 8'd0);
      tick();
      expect_out("div2_p1b", 1'b0, 2'b01, 8'd1);
      Run = 1'b0;
      tick();
      expect_out("div2_exit", 1'b0, 2'b00, 8'd0);
      // Div=0: En every cycle
      Div = 8'd0; Run = 1'b1;
      tick();
      expect_out("div0_entry", 1'b0, 2'b01, 8'd0);
      for (int k = 0; k < 3; k++) begin
         tick();
         expect_out($sformatf("div0_%0d", k), 1'b1, 2'b01, 8'd0);
      end
      Run = 1'b0;
      tick();
      expect_out("div0_exit", 1'b0, 2'b00, 8'd0);
      // max Div: phase reaches 255 without overflow
      Div = 8'd255; Run = 1'b1;
      tick();
      tick(255);
      expect_out("div255_top", 1'b0, 2'b01, 8'd255);
      tick();
      expect_out("div255_wrap", 1'b1, 2'b01, 8'd0);
      // mid-operation reset wins over Run
      Div = 8'd5;
      tick(2);
      Rst_n = 1'b0;
      tick();
      expect_out("mid_reset", 1'b0, 2'b00, 8'd0);
      Rst_n = 1'b1; Run = 1'b0;
      tick();
      expect_out("post_reset", 1'b0, 2'b00, 8'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
